// File: rtl/fir_pipelined_tree.sv
// fir_pipelined_tree: pipelined direct-form FIR with a registered adder tree and loadable coefficients.
// Define FIR_ROUND_SAT_EN for round-half-up, saturating output narrowing and the sat_flag port.
module fir_pipelined_tree #(
    parameter int TAPS   = 64,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int Y_W    = 16,
    parameter int SHIFT  = 15
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         clear,
    input  logic                                         in_valid,
    input  logic signed [DATA_W-1:0]                     in_data,
    input  logic                                         coef_we,
    input  logic        [$clog2(TAPS)-1:0]               coef_addr,
    input  logic signed [COEF_W-1:0]                     coef_data,
    output logic                                         out_valid,
    output logic signed [Y_W-1:0]                        out_data,
    output logic signed [DATA_W+COEF_W+$clog2(TAPS)-1:0] acc_full
`ifdef FIR_ROUND_SAT_EN
    ,
    output logic                                         sat_flag
`endif
);
    localparam int LG    = $clog2(TAPS);
    localparam int P_W   = DATA_W + COEF_W;
    localparam int ACC_W = P_W + LG;
    localparam int L     = LG + 3;

    logic signed [DATA_W-1:0] tap  [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [P_W-1:0]    prod [TAPS];
    logic        [L-1:0]      vld;
    logic signed [ACC_W-1:0]  root;
    logic signed [Y_W-1:0]    y;
    logic                     take;

    // delay line: shifts only on accepted samples, flushed by clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
        else if (clear)
            for (int k = 0; k < TAPS; k++) tap[k] <= '0;
        else if (in_valid) begin
            tap[0] <= in_data;
            for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
        end
    end

    // coefficient bank, survives clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
        else if (coef_we)
            coef[coef_addr] <= coef_data;
    end

    // per-tap products, recomputed every cycle from the current taps and coefficients
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
        else
            for (int k = 0; k < TAPS; k++) prod[k] <= P_W'(tap[k]) * P_W'(coef[k]);
    end

    for (genvar l = 0; l < LG; l++) begin : lvl
        localparam int N = TAPS >> (l + 1);
        localparam int W = P_W + l + 1;
        logic signed [W-2:0] src [2*N];
        logic signed [W-1:0] sum [N];
        if (l == 0) begin : g_first
            assign src = prod;
        end else begin : g_next
            assign src = lvl[l-1].sum;
        end
        // one tree level: pairwise sums with one guard bit so the root cannot overflow
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                for (int i = 0; i < N; i++) sum[i] <= '0;
            else
                for (int i = 0; i < N; i++) sum[i] <= W'(src[2*i]) + W'(src[2*i+1]);
        end
    end

    assign root = lvl[LG-1].sum[0];

    // valid bit travels alongside the data; clear drops everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld <= '0;
        else
            vld <= clear ? '0 : {vld[L-2:0], in_valid};
    end

    assign out_valid = vld[L-1];
    assign take      = vld[L-2] && !clear;

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((64'sd1 <<< SHIFT) >>> 1);
    localparam logic signed [ACC_W:0] HI  = (ACC_W+1)'((64'sd1 <<< (Y_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] LO  = ~HI;

    logic signed [ACC_W:0] shf;
    logic                  sat;

    // round half up, shift, then clamp into the output range
    always_comb begin
        shf = ((ACC_W+1)'(root) + RND) >>> SHIFT;
        sat = (shf > HI) || (shf < LO);
        y   = shf > HI ? Y_W'(HI) : shf < LO ? Y_W'(LO) : Y_W'(shf);
    end

    // clamp indicator pulses only with the sample it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_flag <= 1'b0;
        else
            sat_flag <= take && sat;
    end
`else
    assign y = Y_W'(root >>> SHIFT);
`endif

    // output registers update only for valid samples and hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_full <= '0;
            out_data <= '0;
        end else if (take) begin
            acc_full <= root;
            out_data <= y;
        end
    end
endmodule

// File: tb/tb_fir_pipelined_tree.sv
// tb_fir_pipelined_tree: directed self-checking bench for fir_pipelined_tree (64-tap and 4-tap builds).
`timescale 1ns/1ps
module tb_fir_pipelined_tree;
    localparam int LAT  = 9;
    localparam int LAT2 = 5;

    typedef struct {
        int     d;
        int     c;
        longint acc;
        int     y_trunc;
        int     y_rnd;
        bit     sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic               clear = 1'b0, in_valid = 1'b0, coef_we = 1'b0;
    logic signed [15:0] in_data = '0, coef_data = '0;
    logic        [5:0]  coef_addr = '0;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic signed [37:0] acc_full;

    logic               clear2 = 1'b0, in_valid2 = 1'b0, coef_we2 = 1'b0;
    logic signed [15:0] in_data2 = '0, coef_data2 = '0;
    logic        [1:0]  coef_addr2 = '0;
    logic               out_valid2;
    logic signed [15:0] out_data2;
    logic signed [33:0] acc_full2;
`ifdef FIR_ROUND_SAT_EN
    logic               sat_flag, sat_flag2;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt [8];

    fir_pipelined_tree #(.TAPS(64), .DATA_W(16), .COEF_W(16), .Y_W(16), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .acc_full(acc_full)
`ifdef FIR_ROUND_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    fir_pipelined_tree #(.TAPS(4), .DATA_W(16), .COEF_W(16), .Y_W(16), .SHIFT(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .in_valid(in_valid2), .in_data(in_data2),
        .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_data(coef_data2),
        .out_valid(out_valid2), .out_data(out_data2), .acc_full(acc_full2)
`ifdef FIR_ROUND_SAT_EN
        , .sat_flag(sat_flag2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic load_all(input int base, input int slope);
        for (int k = 0; k < 64; k++) begin
            coef_we   = 1'b1;
            coef_addr = 6'(k);
            coef_data = 16'(base + slope * k);
            step();
        end
        coef_we = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_valid2(output int cnt);
        cnt = 0;
        while (!out_valid2 && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    // impulse through ramp coefficients; gap=1 alternates valid/idle cycles
    task automatic stream(input int gap);
        int     n, k, sent;
        bit     v, ev;
        bit     vh [$];
        longint last, e;
        n    = 65 * (gap + 1) + 12;
        k    = 0;
        sent = 0;
        last = 0;
        for (int t = 0; t < n; t++) begin
            v        = (sent < 65) && (t % (gap + 1) == 0);
            in_valid = v;
            in_data  = !v ? 16'sd7 : (sent == 0 ? 16'sd1 : 16'sd0);
            sent    += int'(v);
            vh.push_back(v);
            step();
            ev = (t >= LAT - 1) ? vh[t-LAT+1] : 1'b0;
            chk($sformatf("stream%0d valid t=%0d", gap, t), longint'(out_valid), longint'(ev));
            if (ev) begin
                e = k < 64 ? k + 1 : 0;
                chk($sformatf("stream%0d out k=%0d", gap, k), out_data, e);
                last = e;
                k++;
            end else
                chk($sformatf("stream%0d hold t=%0d", gap, t), out_data, last);
        end
        in_valid = 1'b0;
        chk($sformatf("stream%0d outputs", gap), k, 65);
    endtask

    initial begin
        int cnt;
        vt[0] = '{3, 1, 3, 1, 2, 1'b0};
        vt[1] = '{-3, 1, -3, -2, -1, 1'b0};
        vt[2] = '{32767, 32767, 1073676289, -32768, 32767, 1'b1};
        vt[3] = '{-32768, 32767, -1073709056, 16384, -32768, 1'b1};
        vt[4] = '{100, -7, -700, -350, -350, 1'b0};
        vt[5] = '{5, 5, 25, 12, 13, 1'b0};
        vt[6] = '{0, 1234, 0, 0, 0, 1'b0};
        vt[7] = '{-1, 1, -1, -1, 0, 1'b0};

        #1 reset = 1'b0;
        step();
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset out_data", out_data, 0);
        chk("reset acc_full", acc_full, 0);
        chk("reset out_valid2", longint'(out_valid2), 0);
        reset = 1'b1;
        step();

        load_all(1, 1);
        stream(0);
        stream(1);

        do_reset();
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_data = 16'sd5;
        in_valid  = 1'b1;
        in_data   = 16'sd3;
        step();
        coef_we  = 1'b0;
        in_valid = 1'b0;
        wait_valid(cnt);
        chk("collide latency", cnt, LAT - 1);
        chk("collide out_data", out_data, 15);
        chk("collide acc_full", acc_full, 15);

        do_reset();
        load_all(32767, 0);
        for (int t = 0; t < 76; t++) begin
            in_valid = t < 64;
            in_data  = 16'sd32767;
            step();
            if (t == 8) chk("ovf first acc", acc_full, 64'd1073676289);
            if (t == 71) begin
                chk("ovf acc_full", acc_full, 64'd68715282496);
`ifdef FIR_ROUND_SAT_EN
                chk("ovf out_data", out_data, 32767);
                chk("ovf sat_flag", longint'(sat_flag), 1);
`else
                chk("ovf out_data", out_data, 64);
`endif
            end
            if (t == 72) begin
                chk("ovf valid end", longint'(out_valid), 0);
`ifdef FIR_ROUND_SAT_EN
                chk("ovf sat_flag end", longint'(sat_flag), 0);
`endif
            end
        end
        in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            coef_we2   = 1'b1;
            coef_addr2 = 2'd0;
            coef_data2 = 16'(vt[i].c);
            in_valid2  = 1'b1;
            in_data2   = 16'(vt[i].d);
            step();
            coef_we2  = 1'b0;
            in_valid2 = 1'b0;
            wait_valid2(cnt);
            chk($sformatf("vec%0d latency", i), cnt, LAT2 - 1);
            chk($sformatf("vec%0d acc_full", i), acc_full2, vt[i].acc);
`ifdef FIR_ROUND_SAT_EN
            chk($sformatf("vec%0d out_data", i), out_data2, vt[i].y_rnd);
            chk($sformatf("vec%0d sat_flag", i), longint'(sat_flag2), longint'(vt[i].sat));
`else
            chk($sformatf("vec%0d out_data", i), out_data2, vt[i].y_trunc);
`endif
            step();
            chk($sformatf("vec%0d valid pulse", i), longint'(out_valid2), 0);
        end

        do_reset();
        load_all(1, 1);
        for (int t = 0; t < 20; t++) begin
            in_valid = 1'b1;
            in_data  = t == 0 ? 16'sd1 : 16'sd0;
            step();
        end
        chk("pre-reset valid", longint'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("async reset out_valid", longint'(out_valid), 0);
        chk("async reset out_data", out_data, 0);
        chk("async reset acc_full", acc_full, 0);
        step();
        reset    = 1'b1;
        in_valid = 1'b0;
        for (int t = 0; t < 15; t++) begin
            step();
            chk($sformatf("post-reset idle t=%0d", t), longint'(out_valid), 0);
        end
        coef_we   = 1'b1;
        coef_addr = 6'd5;
        coef_data = 16'sd2;
        step();
        coef_we = 1'b0;
        for (int t = 0; t < 17; t++) begin
            in_valid = t < 8;
            in_data  = t == 0 ? 16'sd1 : 16'sd0;
            step();
            if (t >= 8 && t < 16) begin
                chk($sformatf("post-reset valid k=%0d", t - 8), longint'(out_valid), 1);
                chk($sformatf("post-reset coef k=%0d", t - 8), out_data, (t - 8 == 5) ? 2 : 0);
            end
            if (t == 16) chk("post-reset end", longint'(out_valid), 0);
        end

        do_reset();
        load_all(1, 1);
        for (int t = 0; t < 24; t++) begin
            in_valid = t <= 11;
            in_data  = t == 0 ? 16'sd1 : (t == 11 ? 16'sd9 : 16'sd0);
            clear    = t == 11;
            step();
            chk($sformatf("clear valid t=%0d", t), longint'(out_valid), longint'(t >= 8 && t <= 10));
            if (t >= 8) chk($sformatf("clear hold t=%0d", t), out_data, t <= 10 ? t - 7 : 3);
        end
        clear = 1'b0;
        for (int t = 0; t < 15; t++) begin
            in_valid = t < 5;
            in_data  = t == 0 ? 16'sd1 : 16'sd0;
            step();
            if (t >= 8 && t < 13) begin
                chk($sformatf("after clear valid k=%0d", t - 8), longint'(out_valid), 1);
                chk($sformatf("after clear out k=%0d", t - 8), out_data, t - 7);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
